// File: rtl/bcd_counter_display.sv
// bcd_counter_display: DIGITS-decade BCD up/down counter with load, wrap/saturate, carry pulse and held 7-seg display
//    clk, reset (async high)  | en, up, load, load_val[4*DIGITS] | hold
//    bcd[4*DIGITS] count      | seg[7*DIGITS] a..g per digit       | carry_out, load_err pulses
module bcd_counter_display #(
   parameter int DIGITS   = 4,
   parameter bit SATURATE = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  up,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  hold,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [7*DIGITS-1:0]   seg,
   output logic                  carry_out,
   output logic                  load_err
);
   localparam logic [4*DIGITS-1:0] MAX_V = {DIGITS{4'h9}};
   logic [4*DIGITS-1:0] count_q, count_d, disp_q, disp_d, inc, dec;
   logic carry_q, carry_d, load_err_q, load_err_d;
   logic all9, all0, ld_ok;
   logic [3:0] d;
   function automatic logic [6:0] seg7(input logic [3:0] v);
      case (v)
         4'd0: seg7 = 7'b1111110;
         4'd1: seg7 = 7'b0110000;
         4'd2: seg7 = 7'b1101101;
         4'd3: seg7 = 7'b1111001;
         4'd4: seg7 = 7'b0110011;
         4'd5: seg7 = 7'b1011011;
         4'd6: seg7 = 7'b1011111;
         4'd7: seg7 = 7'b1110000;
         4'd8: seg7 = 7'b1111111;
         4'd9: seg7 = 7'b1111011;
         default: seg7 = 7'b0000000;
      endcase
   endfunction
   // Ripple the decade carry/borrow: all9/all0 end up true only when every digit is 9/0.
   always_comb begin
      inc = count_q;
      dec = count_q;
      all9 = 1'b1;
      all0 = 1'b1;
      ld_ok = 1'b1;
      d = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         d = count_q[4*i +: 4];
         inc[4*i +: 4] = all9 ? (d == 4'd9 ? 4'd0 : d + 4'd1) : d;
         dec[4*i +: 4] = all0 ? (d == 4'd0 ? 4'd9 : d - 4'd1) : d;
         all9 = all9 & (d == 4'd9);
         all0 = all0 & (d == 4'd0);
         ld_ok = ld_ok & (load_val[4*i +: 4] <= 4'd9);
      end
   end
   // In saturate mode carry also flags the step that first reaches the limit.
   always_comb begin
      count_d = load ? (ld_ok ? load_val : count_q)
              : !en ? count_q
              : up ? ((SATURATE && all9) ? count_q : inc)
              : ((SATURATE && all0) ? count_q : dec);
      carry_d = !load && en && (SATURATE ? (up ? (all9 || inc == MAX_V) : (all0 || dec == '0))
                                         : (up ? all9 : all0));
      load_err_d = load && !ld_ok;
      disp_d = hold ? disp_q : count_q;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
         disp_q <= '0;
         carry_q <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         count_q <= count_d;
         disp_q <= disp_d;
         carry_q <= carry_d;
         load_err_q <= load_err_d;
      end
   end
   always_comb begin
      seg = '0;
      for (int i = 0; i < DIGITS; i++) seg[7*i +: 7] = seg7(disp_q[4*i +: 4]);
   end
   assign bcd = count_q;
   assign carry_out = carry_q;
   assign load_err = load_err_q;
endmodule

// File: tb/tb_bcd_counter_display.sv
// tb_bcd_counter_display: random + directed check of wrap and saturate instances against an integer model
module tb_bcd_counter_display;
   localparam int D = 4;
   localparam int MAX = 9999;
   logic clk = 1'b0;
   logic reset, en, up, load, hold;
   logic [4*D-1:0] load_val, bcd_w, bcd_s;
   logic [7*D-1:0] seg_w, seg_s;
   logic co_w, co_s, le_w, le_s;
   int total = 0, bad = 0;
   int cnt[2], disp[2];
   bit carry[2], lerr[2];
   logic [6:0] segtab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                               7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
   always #5 clk = ~clk;
   bcd_counter_display #(.DIGITS(D), .SATURATE(1'b0)) u_wrap (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val), .hold(hold),
      .bcd(bcd_w), .seg(seg_w), .carry_out(co_w), .load_err(le_w));
   bcd_counter_display #(.DIGITS(D), .SATURATE(1'b1)) u_sat (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val), .hold(hold),
      .bcd(bcd_s), .seg(seg_s), .carry_out(co_s), .load_err(le_s));
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask
   function automatic logic [4*D-1:0] to_bcd(input int v);
      logic [4*D-1:0] r;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction
   function automatic logic [7*D-1:0] to_seg(input int v);
      logic [7*D-1:0] r;
      for (int i = 0; i < D; i++) begin
         r[7*i +: 7] = segtab[v % 10];
         v = v / 10;
      end
      return r;
   endfunction
   task automatic check_all(input string tag);
      chk({tag, ".w.bcd"}, 64'(bcd_w), 64'(to_bcd(cnt[0])));
      chk({tag, ".w.seg"}, 64'(seg_w), 64'(to_seg(disp[0])));
      chk({tag, ".w.co"}, 64'(co_w), 64'(carry[0]));
      chk({tag, ".w.le"}, 64'(le_w), 64'(lerr[0]));
      chk({tag, ".s.bcd"}, 64'(bcd_s), 64'(to_bcd(cnt[1])));
      chk({tag, ".s.seg"}, 64'(seg_s), 64'(to_seg(disp[1])));
      chk({tag, ".s.co"}, 64'(co_s), 64'(carry[1]));
      chk({tag, ".s.le"}, 64'(le_s), 64'(lerr[1]));
   endtask
   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         cnt[k] = 0; disp[k] = 0; carry[k] = 0; lerr[k] = 0;
      end
   endtask
   task automatic model_edge();
      bit ok;
      int val, dg;
      ok = 1; val = 0;
      for (int i = D - 1; i >= 0; i--) begin
         dg = int'(load_val[4*i +: 4]);
         if (dg > 9) ok = 0;
         val = val * 10 + dg;
      end
      for (int k = 0; k < 2; k++) begin
         if (!hold) disp[k] = cnt[k];
         carry[k] = 0;
         lerr[k] = 0;
         if (load) begin
            if (ok) cnt[k] = val; else lerr[k] = 1;
         end else if (en && up) begin
            if (cnt[k] == MAX) begin cnt[k] = (k == 1) ? MAX : 0; carry[k] = 1; end
            else begin cnt[k]++; carry[k] = (k == 1) && cnt[k] == MAX; end
         end else if (en) begin
            if (cnt[k] == 0) begin cnt[k] = (k == 1) ? 0 : MAX; carry[k] = 1; end
            else begin cnt[k]--; carry[k] = (k == 1) && cnt[k] == 0; end
         end
      end
   endtask
   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all(tag);
   endtask
   task automatic drive(input logic e, input logic u, input logic l, input int v, input logic h);
      en = e; up = u; load = l; hold = h; load_val = to_bcd(v);
   endtask
   initial begin
      drive(0, 1, 0, 0, 0);
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      check_all("reset");
      chk("reset.seg0", 64'(seg_w), 64'({4{7'b1111110}}));
      reset = 1'b0;
      step("idle");
      drive(0, 1, 1, 457, 0); step("ld0457");
      drive(1, 1, 0, 0, 0); step("run");
      #2 reset = 1'b1;
      #1 model_reset();
      check_all("async_rst");
      chk("async_rst.seg0", 64'(seg_w), 64'({4{7'b1111110}}));
      @(negedge clk) reset = 1'b0;
      step("post_rst");
      chk("post_rst.one", 64'(bcd_w), 64'(16'h0001));
      drive(0, 1, 1, 998, 0); step("ld0998");
      drive(1, 1, 0, 0, 0); step("up0999");
      step("up1000");
      chk("up1000.lit", 64'(bcd_w), 64'(16'h1000));
      drive(0, 1, 1, 9999, 0); step("ld9999");
      drive(1, 1, 0, 0, 0); step("wrap_up");
      chk("wrap_up.co", 64'(co_w), 64'(1'b1));
      drive(0, 0, 1, 0, 0); step("ld0000");
      drive(1, 0, 0, 0, 0); step("wrap_dn");
      chk("wrap_dn.bcd", 64'(bcd_w), 64'(16'h9999));
      drive(0, 1, 1, 9998, 0); step("ld9998");
      drive(1, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step("sat_up");
         chk("sat_up.co", 64'(co_s), 64'(1'b1));
      end
      drive(1, 0, 0, 0, 0); step("sat_dn");
      chk("sat_dn.bcd", 64'(bcd_s), 64'(16'h9998));
      drive(0, 1, 1, 123, 0); step("ld0123");
      en = 1'b1; load = 1'b1; load_val = 16'h12A4; step("bad_ld");
      chk("bad_ld.le", 64'(le_w), 64'(1'b1));
      drive(1, 1, 0, 0, 0); step("after_bad");
      chk("after_bad.bcd", 64'(bcd_w), 64'(16'h0124));
      drive(0, 1, 1, 50, 0); step("ld0050");
      step("disp0050");
      drive(1, 1, 0, 0, 1);
      for (int i = 0; i < 10; i++) step("hold_run");
      chk("hold.seg", 64'(seg_w), 64'(to_seg(50)));
      drive(0, 1, 0, 0, 0); step("release");
      chk("release.seg", 64'(seg_w), 64'(to_seg(60)));
      for (int n = 0; n < 3000; n++) begin
         int v, pick;
         pick = $urandom_range(0, 4);
         v = pick == 0 ? 9999 : pick == 1 ? 0 : pick == 2 ? 9998 : pick == 3 ? 1 : int'($urandom_range(0, MAX));
         drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1), ($urandom_range(0, 15) == 0), v,
               ($urandom_range(0, 7) == 0));
         if ($urandom_range(0, 3) == 0) load_val[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
         step("rand");
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/bcd_counter_display.md
Name: bcd_counter_display

Overview:
Parametrised multi-digit decimal counter with integrated display path. It counts up or down in BCD across DIGITS cascaded decades and supports synchronous load, wrap or saturate modes, and carry/borrow signalling. A hold-capable display register drives a per-digit 7-segment decoder. It is the front end for multi-digit counters and timers driving the board's 7-segment displays.

Parameters:
DIGITS, 4, number of BCD decades (1..8); digit 0 is least significant.
SATURATE, 0, 0 = wrap at the count limits; 1 = stick at 99..9 counting up and at 00..0 counting down.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
en  input  1  count enable; one step per clk edge while high.
up  input  1  direction select: 1 = increment, 0 = decrement.
load  input  1  synchronous load request.
load_val  input  4*DIGITS  BCD value to load; digit i occupies bits [4i+3:4i].
hold  input  1  1 = freeze the display register; the counter keeps running.
bcd  output  4*DIGITS  current count, registered, packed as in load_val.
seg  output  7*DIGITS  segments for digit i at [7i+6:7i], order a..g MSB..LSB, 1 = segment lit.
carry_out  output  1  one-cycle pulse when a step crosses or hits a count limit.
load_err  output  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (asynchronous, active-high) sets count = 0, display register = 0, carry_out = 0, load_err = 0. While reset is high, seg shows "0" on every digit (1111110 per digit).
- Per-edge priority: reset > load > en. With load high, en is ignored that cycle.
- Load, all digits ≤ 9: count <= load_val next edge; carry_out = 0.
- Load, any digit > 9: count unchanged, no count step that cycle, load_err = 1 for exactly that cycle.
- Up step: digit 0 increments every enabled cycle. Digit i increments only when all lower digits are 9. Any digit at 9 that increments becomes 0.
- Down step: digit 0 decrements every enabled cycle. Digit i decrements only when all lower digits are 0. Any digit at 0 that decrements becomes 9.
- Limits, SATURATE = 0:
  - 99..9 up becomes 00..0.
  - 00..0 down becomes 99..9.
  - carry_out = 1 in the cycle the wrapped value appears on bcd.
- Limits, SATURATE = 1:
  - Count holds at 99..9 (up) or 00..0 (down).
  - carry_out = 1 on every enabled cycle attempted at the limit, including the cycle the limit is first reached.
- en low and no load: count holds; carry_out = 0.
- up may change on any cycle; each step uses the value of up sampled at that edge.
- Display register:
  - hold = 0: captures the current registered count every edge, so seg lags bcd by exactly 1 cycle.
  - hold = 1: display register keeps its value and seg is frozen.
  - On release of hold, seg reflects the new count 1 edge later.
- Decoder: combinational from the display register. Encoding 0..9 = 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011. Non-BCD input gives 0000000; unreachable by construction.
- Reset asserted mid-count or mid-hold clears immediately, with no clock required. The first step after reset deasserts starts from 0.
- carry_out and load_err are registered, never high together, and always 0 in the cycle after reset.

Test Plan:
- Reset with count 0457, assert reset mid-cycle -> bcd = 0000 and seg = four × 1111110 before the next clk edge.
- DIGITS=4, load 0998, en=1, up=1 for 2 cycles -> bcd 0999 then 1000; seg shows 0999 one cycle after bcd does; carry_out stays 0.
- Load 9999, up=1, one step, SATURATE=0 -> bcd 0000, carry_out = 1 for that single cycle. Load 0000, up=0, one step -> bcd 9999, carry_out = 1.
- SATURATE=1, load 9998, up=1, en=1 for 3 cycles -> bcd 9999, 9999, 9999; carry_out = 1 on all three cycles. Then up=0 for 1 cycle -> bcd 9998, carry_out = 0.
- Count at 0123, load 12A4 with en=1 -> bcd stays 0123 (no step), load_err = 1 for 1 cycle. Next cycle with en=1, up=1 -> bcd 0124.
- hold=1 at count 0050, run 10 up steps -> seg frozen at 0050 while bcd reaches 0060. Release hold -> seg shows 0060 (or the then-current count) after 1 edge.
